// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen countdown timer: FSM encoding and BCD limits.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam logic [3:0] BLANK_CODE   = 4'hF;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with synchronous clear/inc/dec; wraps at MAX and flags carry/borrow.
module bcd_digit #(
   parameter logic [3:0] MAX = timer_pkg::DIGIT_MAX
) (
   input  logic       sclk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] q,
   output logic [3:0] q_nxt,
   output logic       carry,
   output logic       borrow
);

   // clear dominates; inc and dec are never requested together by the controller
   always_comb begin
      q_nxt = q;
      if (clr)
         q_nxt = 4'd0;
      else if (inc)
         q_nxt = (q == MAX) ? 4'd0 : q + 4'd1;
      else if (dec)
         q_nxt = (q == 4'd0) ? MAX : q - 4'd1;
   end

   assign carry  = !clr && inc && (q == MAX);
   assign borrow = !clr && !inc && dec && (q == 4'd0);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset)
         q <= 4'd0;
      else
         q <= q_nxt;
   end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// MM:SS countdown controller with button set mode, pause, and a flashing timed alarm.
module kitchen_timer_ctrl #(
   parameter int         ALARM_SECS = 30,
   parameter logic [3:0] BLANK_CODE = timer_pkg::BLANK_CODE
) (
   input  logic       sclk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       btn_start,
   input  logic       btn_min,
   input  logic       btn_sec,
   input  logic       btn_clear,
   output logic [3:0] dleft,
   output logic [3:0] dmidleft,
   output logic [3:0] dmidright,
   output logic [3:0] dright,
   output logic       running,
   output logic       alarm
);
   import timer_pkg::*;

   localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);

   state_t          state, state_nxt;
   logic [7:0]      acnt, acnt_nxt;
   logic            phase, phase_nxt;
   logic            clr, sec_inc, min_inc, dec_all;
   logic [3:0][3:0] q, q_nxt;   // [0]=sec units .. [3]=min tens
   logic [3:0]      inc, dec, carry, borrow;
   logic            time_zero, time_one, any_btn, show_blank;
   logic            unused_wraps;

   // decrement borrows ripple through all four digits; increments stay
   // inside the seconds pair or the minutes pair
   for (genvar gi = 0; gi < 4; gi++) begin : gen_dig
      if (gi == 0) begin : g_lsd
         assign inc[gi] = sec_inc;
         assign dec[gi] = dec_all;
      end else if (gi == 2) begin : g_min
         assign inc[gi] = min_inc;
         assign dec[gi] = borrow[gi-1];
      end else begin : g_chain
         assign inc[gi] = carry[gi-1];
         assign dec[gi] = borrow[gi-1];
      end

      bcd_digit #(.MAX(gi == 1 ? SEC_TENS_MAX : DIGIT_MAX)) u_dig (
         .sclk   (sclk),
         .reset  (reset),
         .clr    (clr),
         .inc    (inc[gi]),
         .dec    (dec[gi]),
         .q      (q[gi]),
         .q_nxt  (q_nxt[gi]),
         .carry  (carry[gi]),
         .borrow (borrow[gi])
      );
   end

   assign unused_wraps = &{carry[3], carry[1], borrow[3]};

   assign time_zero = (q == 16'h0000);
   assign time_one  = (q == 16'h0001);
   assign any_btn   = btn_start | btn_min | btn_sec | btn_clear;

   always_comb begin
      state_nxt = state;
      acnt_nxt  = acnt;
      phase_nxt = phase;
      clr       = 1'b0;
      sec_inc   = 1'b0;
      min_inc   = 1'b0;
      dec_all   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (btn_clear)
               clr = 1'b1;
            else if (btn_start) begin
               if (!time_zero) state_nxt = ST_RUN;
            end else if (btn_min)
               min_inc = 1'b1;
            else if (btn_sec)
               sec_inc = 1'b1;
         end
         ST_RUN: begin
            if (btn_clear) begin
               clr       = 1'b1;
               state_nxt = ST_IDLE;
            end else if (btn_start)
               state_nxt = ST_PAUSE;
            else if (tick_1hz) begin
               dec_all = 1'b1;
               if (time_one) state_nxt = ST_ALARM;
            end
         end
         ST_PAUSE: begin
            if (btn_clear) begin
               clr       = 1'b1;
               state_nxt = ST_IDLE;
            end else if (btn_start)
               state_nxt = ST_RUN;
         end
         ST_ALARM: begin
            if (any_btn || (tick_1hz && (acnt + 8'd1 == ALARM_LIM))) begin
               clr       = 1'b1;
               state_nxt = ST_IDLE;
               acnt_nxt  = 8'd0;
               phase_nxt = 1'b0;
            end else if (tick_1hz) begin
               acnt_nxt  = acnt + 8'd1;
               phase_nxt = !phase;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // outputs are registered from next-state values so they move on the same edge
   assign show_blank = (state_nxt == ST_ALARM) && phase_nxt;

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         acnt    <= 8'd0;
         phase   <= 1'b0;
         {dleft, dmidleft, dmidright, dright} <= 16'h0000;
         running <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         state   <= state_nxt;
         acnt    <= acnt_nxt;
         phase   <= phase_nxt;
         {dleft, dmidleft, dmidright, dright} <= show_blank ? {4{BLANK_CODE}} : q_nxt;
         running <= (state_nxt == ST_RUN);
         alarm   <= (state_nxt == ST_ALARM);
      end
   end

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Directed vector table plus hand sequences for the kitchen timer controller.
module tb_kitchen_timer_ctrl;

   logic       sclk = 1'b0;
   logic       reset;
   logic       tick_1hz, btn_start, btn_min, btn_sec, btn_clear;
   logic [3:0] dleft, dmidleft, dmidright, dright;
   logic       running, alarm;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        tick, start, mn, sc, clr;
      logic [15:0] d;
      logic        r, a;
      string       nm;
   } vec_t;

   vec_t vt[$];

   kitchen_timer_ctrl #(.ALARM_SECS(4), .BLANK_CODE(4'hF)) dut (
      .sclk      (sclk),
      .reset     (reset),
      .tick_1hz  (tick_1hz),
      .btn_start (btn_start),
      .btn_min   (btn_min),
      .btn_sec   (btn_sec),
      .btn_clear (btn_clear),
      .dleft     (dleft),
      .dmidleft  (dmidleft),
      .dmidright (dmidright),
      .dright    (dright),
      .running   (running),
      .alarm     (alarm)
   );

   always #5 sclk = ~sclk;

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic check(input string nm, input logic [15:0] d, input logic r, input logic a);
      logic [15:0] got;
      got = {dleft, dmidleft, dmidright, dright};
      checks++;
      if (got !== d || running !== r || alarm !== a) begin
         errors++;
         $display("FAIL %s: got digits=%h running=%b alarm=%b, expected digits=%h running=%b alarm=%b",
                  nm, got, running, alarm, d, r, a);
      end
   endtask

   task automatic step(input logic t, input logic s, input logic m, input logic sc, input logic c);
      @(negedge sclk);
      tick_1hz = t; btn_start = s; btn_min = m; btn_sec = sc; btn_clear = c;
      @(posedge sclk);
      #1;
      tick_1hz = 0; btn_start = 0; btn_min = 0; btn_sec = 0; btn_clear = 0;
   endtask

   task automatic press_n(input int n, input logic m, input logic sc);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, m, sc, 1'b0);
   endtask

   initial begin
      //            tick start min sec clr digits    run alm
      vt.push_back('{0, 0, 1, 0, 0, 16'h0100, 0, 0, "idle_min"});
      vt.push_back('{1, 0, 1, 0, 0, 16'h0200, 0, 0, "min_beats_tick"});
      vt.push_back('{0, 0, 0, 1, 0, 16'h0201, 0, 0, "idle_sec"});
      vt.push_back('{0, 0, 1, 1, 0, 16'h0301, 0, 0, "min_beats_sec"});
      vt.push_back('{1, 1, 1, 1, 0, 16'h0301, 1, 0, "start_beats_all"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0300, 1, 0, "run_tick"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0259, 1, 0, "run_borrow"});
      vt.push_back('{0, 0, 1, 1, 0, 16'h0259, 1, 0, "run_ignores_set"});
      vt.push_back('{0, 1, 0, 0, 0, 16'h0259, 0, 0, "pause"});
      vt.push_back('{1, 0, 1, 0, 0, 16'h0259, 0, 0, "pause_hold"});
      vt.push_back('{0, 1, 0, 0, 0, 16'h0259, 1, 0, "resume"});
      vt.push_back('{0, 1, 0, 0, 1, 16'h0000, 0, 0, "clear_beats_start"});
      vt.push_back('{0, 1, 0, 0, 0, 16'h0000, 0, 0, "start_at_zero"});
      vt.push_back('{0, 0, 0, 1, 0, 16'h0001, 0, 0, "set_0001"});
      vt.push_back('{0, 1, 0, 0, 0, 16'h0001, 1, 0, "run_0001"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0000, 0, 1, "alarm_enter"});
      vt.push_back('{1, 0, 0, 0, 0, 16'hFFFF, 0, 1, "alarm_blank1"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0000, 0, 1, "alarm_show2"});
      vt.push_back('{1, 0, 0, 0, 0, 16'hFFFF, 0, 1, "alarm_blank3"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0000, 0, 0, "alarm_timeout"});
      vt.push_back('{1, 0, 0, 0, 0, 16'h0000, 0, 0, "idle_ignores_tick"});

      reset = 1'b1;
      tick_1hz = 0; btn_start = 0; btn_min = 0; btn_sec = 0; btn_clear = 0;
      #1;
      check("reset_state", 16'h0000, 1'b0, 1'b0);
      repeat (2) @(posedge sclk);
      @(negedge sclk) reset = 1'b0;

      foreach (vt[i]) begin
         step(vt[i].tick, vt[i].start, vt[i].mn, vt[i].sc, vt[i].clr);
         check(vt[i].nm, vt[i].d, vt[i].r, vt[i].a);
      end

      // 01:05 full countdown into alarm
      step(0, 0, 0, 0, 1);
      press_n(1, 1'b1, 1'b0);
      press_n(5, 1'b0, 1'b1);
      check("set_0105", 16'h0105, 1'b0, 1'b0);
      step(0, 1, 0, 0, 0);
      check("start_0105", 16'h0105, 1'b1, 1'b0);
      for (int k = 1; k <= 65; k++) begin
         step(1, 0, 0, 0, 0);
         check($sformatf("countdown_%0d", k), to_bcd(65 - k), k < 65, k == 65);
      end
      step(0, 0, 0, 0, 1);
      check("alarm_clear_btn", 16'h0000, 1'b0, 1'b0);

      // set-mode wraps without carry
      press_n(61, 1'b0, 1'b1);
      check("sec_61_presses", 16'h0001, 1'b0, 1'b0);
      press_n(100, 1'b1, 1'b0);
      check("min_100_presses", 16'h0001, 1'b0, 1'b0);
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0);
      check("start_zero_after_clear", 16'h0000, 1'b0, 1'b0);

      // pause with coincident tick at 02:00
      press_n(2, 1'b1, 1'b0);
      step(0, 1, 0, 0, 0);
      check("run_0200", 16'h0200, 1'b1, 1'b0);
      step(1, 1, 0, 0, 0);
      check("pause_tick_coincide", 16'h0200, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
      check("pause_5_ticks", 16'h0200, 1'b0, 1'b0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("resume_tick_0159", 16'h0159, 1'b1, 1'b0);

      // button during alarm returns to idle without applying its action
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("alarm2_enter", 16'h0000, 1'b0, 1'b1);
      step(1, 0, 0, 0, 0);
      check("alarm2_blank", 16'hFFFF, 1'b0, 1'b1);
      step(1, 0, 1, 0, 0);
      check("alarm2_min_abort", 16'h0000, 1'b0, 1'b0);

      // clear and start together while running at 10:30
      press_n(10, 1'b1, 1'b0);
      press_n(30, 1'b0, 1'b1);
      step(0, 1, 0, 0, 0);
      check("run_1030", 16'h1030, 1'b1, 1'b0);
      step(0, 1, 0, 0, 1);
      check("clear_start_1030", 16'h0000, 1'b0, 1'b0);

      // asynchronous reset between edges at 09:59
      press_n(9, 1'b1, 1'b0);
      press_n(59, 1'b0, 1'b1);
      step(0, 1, 0, 0, 0);
      check("run_0959", 16'h0959, 1'b1, 1'b0);
      @(negedge sclk);
      #2 reset = 1'b1;
      #1;
      check("async_reset", 16'h0000, 1'b0, 1'b0);
      @(posedge sclk);
      @(negedge sclk) reset = 1'b0;
      step(1, 0, 0, 0, 0);
      check("after_reset_idle", 16'h0000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kitchen_timer_ctrl.md
Name: kitchen_timer_ctrl

Overview:
Countdown sequencer for the four-digit seven-segment display multiplexer. It holds a BCD MM:SS time value and lets the user set it with minute/second buttons. It counts down on a 1 Hz enable and raises a timed alarm at 00:00. Its four BCD digit outputs drive the multiplexer's dleft/dmidleft/dmidright/dright inputs directly, and BLANK_CODE shows as all-segments-off there.

Parameters:
ALARM_SECS, 30, number of tick_1hz pulses the alarm stays active before auto-return to IDLE (1..255)
BLANK_CODE, 4'hF, digit code emitted while the alarm flash is in its blank phase

Ports:
sclk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  single-cycle enable pulse, once per second
btn_start  in  1  single-cycle debounced pulse: start/pause toggle
btn_min  in  1  single-cycle pulse: minutes +1 (set mode only)
btn_sec  in  1  single-cycle pulse: seconds +1 (set mode only)
btn_clear  in  1  single-cycle pulse: abort and zero
dleft  out  4  minutes tens (BCD or BLANK_CODE)
dmidleft  out  4  minutes units
dmidright  out  4  seconds tens
dright  out  4  seconds units
running  out  1  high in RUN
alarm  out  1  high in ALARM

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock sclk.
- Reset values: all digits 0, running 0, alarm 0, state IDLE, alarm counter 0, flash phase 0.
- All outputs are registered. An input event is visible on the outputs one sclk edge later.
- States: IDLE, RUN, PAUSE, ALARM.
- Same-cycle input priority: btn_clear > btn_start > btn_min > btn_sec > tick_1hz. Exactly one action is taken per cycle; lower-priority inputs in that cycle are dropped.
- IDLE:
  - btn_min: minutes +1, wrapping 99->00; seconds unchanged.
  - btn_sec: seconds +1, wrapping 59->00; no carry into minutes.
  - btn_start with time != 00:00: go to RUN. With time = 00:00 the press is ignored.
  - btn_clear: time = 00:00.
  - tick is ignored.
- RUN:
  - tick: decrement by one second. Seconds units borrow 0->9; seconds tens borrow 0->5; a minutes borrow occurs when seconds go 00->59.
  - If the time before the tick is 00:01, the same edge sets 00:00 and enters ALARM.
  - btn_start: go to PAUSE with no decrement, even if a tick coincides.
  - btn_clear: go to IDLE with time 00:00.
  - btn_min and btn_sec are ignored.
- PAUSE:
  - Time is held; tick, btn_min and btn_sec are ignored.
  - btn_start: go to RUN. The next tick decrements.
  - btn_clear: go to IDLE with 00:00.
- ALARM:
  - alarm = 1; the time register holds 00:00.
  - On each tick the flash phase toggles. While phase = 1, all four digit outputs show BLANK_CODE; while phase = 0 they show 0.
  - On each tick the alarm counter increments. When it reaches ALARM_SECS, go to IDLE.
  - Any of btn_start, btn_min, btn_sec or btn_clear goes to IDLE immediately; that button's normal action is not applied.
  - Leaving ALARM clears alarm, the counter and the phase, and the outputs show 0000.
- running = (state == RUN). alarm = (state == ALARM).
- Digits never hold illegal BCD: seconds tens is 0..5, all others 0..9, BLANK_CODE only in ALARM.
- Reset asserted mid-count or mid-alarm returns everything to the reset values immediately (asynchronous).

Decomposition:
- Shared package (timer_pkg): state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3), BLANK_CODE, and BCD limits SEC_TENS_MAX=5, DIGIT_MAX=9.
- One natural sub-module, bcd_digit:
  - A 4-bit BCD counter with synchronous inc/dec enables and a parameterized maximum.
  - Outputs carry-out on max->0 and borrow-out on 0->max.
  - Instantiated four times and chained for the borrow. Increment carries are not chained, per the set-mode rules.

Test Plan:
- Set 01:05 in IDLE, then start and apply 65 ticks -> digits count 0105, 0104 ... 0100, 0059 ... 0001, then 0000 with alarm=1 and running=0 on the 65th tick edge.
- Press btn_sec 61 times from 00:00 -> 0001; press btn_min 100 times -> 0001 (minutes wrap, no carry); then btn_start at 00:00 after clear -> stays IDLE, running=0.
- RUN at 02:00: btn_start coincident with tick -> PAUSE and digits 0200; 5 ticks -> 0200; btn_start then 1 tick -> 0159.
- ALARM with ALARM_SECS=4: ticks show digits alternating FFFF/0000, and after the 4th tick state=IDLE, alarm=0, digits 0000. Repeat and press btn_min on the 2nd tick -> IDLE immediately, digits 0000 (not 0100).
- btn_clear and btn_start in the same cycle in RUN at 10:30 -> IDLE with 0000.
- Assert reset asynchronously mid-RUN at 09:59 between clock edges -> outputs 0000, running=0, alarm=0 before the next sclk edge.
